// File: rtl/soc_it_xfer_arbiter_if.sv
// Handshake bundle between the soc_it handlers, the transfer arbiter and the AXI transfer engine.
// The arbiter connects through the master modport; the environment connects through the slave modport.
interface soc_it_xfer_arbiter_if #(
   parameter int N_REQ             = 4,
   parameter int XFER_PARAMS_WIDTH = 79,
   parameter int ID_W              = 2
);
   logic [N_REQ*XFER_PARAMS_WIDTH-1:0] req_params_i;
   logic [N_REQ-1:0]                   req_valid_i;
   logic [N_REQ-1:0]                   req_ack_o;

   logic [XFER_PARAMS_WIDTH-1:0]       desc_o;
   logic [ID_W-1:0]                    desc_id_o;
   logic                               desc_valid_o;
   logic                               desc_ready_i;

   logic [N_REQ-1:0]                   req_wvalid_i;
   logic [N_REQ-1:0]                   req_wlast_i;
   logic [N_REQ-1:0]                   req_wready_o;
   logic                               m_wvalid_o;
   logic                               m_wlast_o;
   logic                               m_wready_i;

   logic                               m_rvalid_i;
   logic                               m_rlast_i;
   logic                               m_rready_o;
   logic [N_REQ-1:0]                   req_rvalid_o;
   logic [N_REQ-1:0]                   req_rlast_o;
   logic [N_REQ-1:0]                   req_rready_i;

   logic                               busy_o;
   logic                               timeout_err_o;
   logic [1:0]                         state_dbg;

   modport master (
      input  req_params_i, req_valid_i, desc_ready_i,
      input  req_wvalid_i, req_wlast_i, m_wready_i,
      input  m_rvalid_i, m_rlast_i, req_rready_i,
      output req_ack_o, desc_o, desc_id_o, desc_valid_o,
      output req_wready_o, m_wvalid_o, m_wlast_o,
      output m_rready_o, req_rvalid_o, req_rlast_o,
      output busy_o, timeout_err_o, state_dbg
   );

   modport slave (
      output req_params_i, req_valid_i, desc_ready_i,
      output req_wvalid_i, req_wlast_i, m_wready_i,
      output m_rvalid_i, m_rlast_i, req_rready_i,
      input  req_ack_o, desc_o, desc_id_o, desc_valid_o,
      input  req_wready_o, m_wvalid_o, m_wlast_o,
      input  m_rready_o, req_rvalid_o, req_rlast_o,
      input  busy_o, timeout_err_o, state_dbg
   );
endinterface

// File: rtl/soc_it_xfer_arbiter.sv
// Round-robin arbiter sharing one transfer engine between N_REQ soc_it handlers, one transfer at a time,
// with exclusive beat routing to the granted handler and a data-phase watchdog.
module soc_it_xfer_arbiter #(
   parameter int N_REQ               = 4,
   parameter int C_SLV_ADDRESS_WIDTH = 64,
   parameter int C_SLV_BURST_LENGTH  = 13,
   parameter int XFER_PARAMS_WIDTH   = C_SLV_ADDRESS_WIDTH + C_SLV_BURST_LENGTH + 2,
   parameter int TIMEOUT_CYCLES      = 4096
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   soc_it_xfer_arbiter_if.master bus
);
   localparam int ID_W  = $clog2(N_REQ);
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int RNW_BIT = XFER_PARAMS_WIDTH - 2;

   // Valid/ready rule on every channel: a transfer happens in a cycle where both valid and ready
   // are high at the clock edge; valid may not depend on ready, ready may depend on valid.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DATA  = 2'd2
   } state_e;

   state_e                       state_q, state_d;
   logic [ID_W-1:0]              grant_q;
   logic [ID_W-1:0]              last_grant_q;
   logic                         rnw_q;
   logic [XFER_PARAMS_WIDTH-1:0] desc_q;
   logic [N_REQ-1:0]             ack_q;
   logic                         err_q;
   logic [CNT_W-1:0]             wd_cnt_q;
   logic [CNT_W-1:0]             wd_inc;

   logic [ID_W-1:0]              scan_idx;
   logic [ID_W-1:0]              pick;
   logic                         pick_vld;
   logic [XFER_PARAMS_WIDTH-1:0] pick_desc;
   logic                         beat_done;
   logic                         last_done;
   logic                         wd_expire;

   // Round-robin scan starting just after the previous winner, wrapping at N_REQ.
   always_comb begin
      scan_idx = '0;
      pick     = '0;
      pick_vld = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         scan_idx = ID_W'((int'(last_grant_q) + k) % N_REQ);
         if (!pick_vld && bus.req_valid_i[scan_idx]) begin
            pick_vld = 1'b1;
            pick     = scan_idx;
         end
      end
   end

   assign pick_desc = bus.req_params_i[int'(pick)*XFER_PARAMS_WIDTH +: XFER_PARAMS_WIDTH];

   // Beat routing: only the granted lane in the selected direction is ever connected.
   always_comb begin
      bus.m_wvalid_o   = 1'b0;
      bus.m_wlast_o    = 1'b0;
      bus.req_wready_o = '0;
      bus.m_rready_o   = 1'b0;
      bus.req_rvalid_o = '0;
      bus.req_rlast_o  = '0;
      if (state_q == ST_DATA) begin
         if (rnw_q) begin
            bus.req_rvalid_o[grant_q] = bus.m_rvalid_i;
            bus.req_rlast_o[grant_q]  = bus.m_rlast_i;
            bus.m_rready_o            = bus.req_rready_i[grant_q];
         end else begin
            bus.m_wvalid_o            = bus.req_wvalid_i[grant_q];
            bus.m_wlast_o             = bus.req_wlast_i[grant_q];
            bus.req_wready_o[grant_q] = bus.m_wready_i;
         end
      end
   end

   always_comb begin
      beat_done = 1'b0;
      last_done = 1'b0;
      if (state_q == ST_DATA) begin
         if (rnw_q) begin
            beat_done = bus.m_rvalid_i & bus.m_rready_o;
            last_done = beat_done & bus.m_rlast_i;
         end else begin
            beat_done = bus.m_wvalid_o & bus.m_wready_i;
            last_done = beat_done & bus.m_wlast_o;
         end
      end
   end

   // The watchdog fires on the cycle the saturating counter would reach its terminal value.
   always_comb begin
      wd_inc    = (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES)) ? wd_cnt_q : wd_cnt_q + CNT_W'(1);
      wd_expire = 1'b0;
      if ((TIMEOUT_CYCLES != 0) && (state_q == ST_DATA) && !beat_done) begin
         wd_expire = (wd_inc == CNT_W'(TIMEOUT_CYCLES));
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      bus.desc_valid_o  = 1'b0;
      bus.busy_o        = 1'b0;
      bus.state_dbg     = state_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            bus.desc_valid_o = 1'b1;
            bus.busy_o       = 1'b1;
            if (bus.desc_ready_i) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            bus.busy_o = 1'b1;
            if (last_done || wd_expire) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         grant_q      <= '0;
         last_grant_q <= ID_W'(N_REQ - 1);
         rnw_q        <= 1'b0;
         desc_q       <= '0;
         ack_q        <= '0;
         err_q        <= 1'b0;
         wd_cnt_q     <= '0;
      end else begin
         ack_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (pick_vld) begin
                  grant_q      <= pick;
                  last_grant_q <= pick;
                  desc_q       <= pick_desc;
                  rnw_q        <= pick_desc[RNW_BIT];
               end
            end
            ST_ISSUE: begin
               if (bus.desc_ready_i) begin
                  ack_q[grant_q] <= 1'b1;
                  wd_cnt_q       <= '0;
               end
            end
            ST_DATA: begin
               if (beat_done) begin
                  wd_cnt_q <= '0;
               end else if (TIMEOUT_CYCLES != 0) begin
                  wd_cnt_q <= wd_inc;
               end
               if (wd_expire) begin
                  err_q <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.req_ack_o     = ack_q;
   assign bus.desc_o        = desc_q;
   assign bus.desc_id_o     = grant_q;
   assign bus.timeout_err_o = err_q;

endmodule

// File: doc/soc_it_xfer_arbiter.md
# soc_it_xfer_arbiter

Shares one AXI-domain transfer engine between `N_REQ` soc_it handlers. Each handler raises a transfer descriptor request. The arbiter picks one requester round-robin and forwards its descriptor downstream. It then pulses that requester's ack and routes the W or R beat channel exclusively to it until the last beat. Only one transfer is outstanding at a time; a watchdog aborts a stalled data phase.

## Interface
- `N_REQ`, 4: number of handler ports, 2..16.
- `C_SLV_ADDRESS_WIDTH`, 64: address field width.
- `C_SLV_BURST_LENGTH`, 13: byte-length field width.
- `XFER_PARAMS_WIDTH`, `C_SLV_ADDRESS_WIDTH+C_SLV_BURST_LENGTH+2`: descriptor width. Bit layout: `{start, rnw, length, address}`, MSB first.
- `TIMEOUT_CYCLES`, 4096: maximum beat-free cycles allowed in the data phase; 0 disables the watchdog.
- `clk_i` in 1: the single clock.
- `rst_ni` in 1: reset, asynchronous assert, active-low.
- `req_params_i` in `N_REQ*XFER_PARAMS_WIDTH`: per-requester descriptor; slice i belongs to requester i.
- `req_valid_i` in `N_REQ`: descriptor request; held until ack.
- `req_ack_o` out `N_REQ`: one-cycle, one-hot ack.
- `desc_o` out `XFER_PARAMS_WIDTH`: descriptor sent to the engine.
- `desc_id_o` out `$clog2(N_REQ)`: index of the granted requester.
- `desc_valid_o` out 1 / `desc_ready_i` in 1: descriptor valid/ready pair.
- `req_wvalid_i`, `req_wlast_i` in `N_REQ`; `req_wready_o` out `N_REQ`: per-requester write-beat handshake.
- `m_wvalid_o`, `m_wlast_o` out 1; `m_wready_i` in 1: write-beat handshake to the engine.
- `m_rvalid_i`, `m_rlast_i` in 1; `m_rready_o` out 1: read-beat handshake from the engine.
- `req_rvalid_o`, `req_rlast_o` out `N_REQ`; `req_rready_i` in `N_REQ`: per-requester read-beat handshake.
- `busy_o` out 1: asserted whenever the state is not IDLE.
- `timeout_err_o` out 1: sticky watchdog flag.

## Operation
- States:
  - IDLE: arbitrate among `req_valid_i`.
  - ISSUE: `desc_valid_o` is high.
  - DATA: the beat channel is routed to the granted requester.
- IDLE:
  - If any `req_valid_i` is set, grant the first set bit scanning from `(last_grant+1) mod N_REQ` upward with wrap.
  - Register `grant`, `desc_o = req_params_i[grant]`, `desc_id_o = grant` and `rnw = desc_o[XFER_PARAMS_WIDTH-2]`.
  - Update `last_grant` and go to ISSUE.
- ISSUE:
  - Hold `desc_valid_o=1` with `desc_o` stable.
  - On `desc_ready_i`, register `req_ack_o[grant]=1` for exactly one cycle and go to DATA.
- DATA, write (`rnw=0`):
  - `m_wvalid_o = req_wvalid_i[grant]` and `m_wlast_o = req_wlast_i[grant]`.
  - `req_wready_o[grant] = m_wready_i`.
  - A beat with `wvalid & wready & wlast` returns the state to IDLE.
- DATA, read (`rnw=1`):
  - `req_rvalid_o[grant] = m_rvalid_i` and `req_rlast_o[grant] = m_rlast_i`.
  - `m_rready_o = req_rready_i[grant]`.
  - A beat with `rvalid & rready & rlast` returns the state to IDLE.
- Routing rules:
  - Routed beat outputs are combinational.
  - Every non-granted lane, and every lane outside DATA, is driven 0.
  - The unused direction is driven 0.
  - `m_rready_o` is 0 outside a read DATA phase, so engine read data stalls.
- Watchdog:
  - A counter clears on entry to DATA and on every completed beat, and increments otherwise.
  - When it reaches `TIMEOUT_CYCLES` (nonzero), set `timeout_err_o` and go to IDLE. The aborted requester receives no further beats.
  - `timeout_err_o` clears only on reset.
- Requests from non-granted ports are held off with no ack and remain pending.
- `req_valid_i` changes during ISSUE or DATA are ignored.

## Timing
- Reset values:
  - State IDLE; `last_grant = N_REQ-1`, so requester 0 has priority first.
  - All outputs 0: `desc_o`, `desc_id_o`, `desc_valid_o`, `req_ack_o`, `busy_o`, `timeout_err_o` and every beat output.
- Asynchronous reset in any state, including mid-burst: next edge finds state IDLE with all outputs 0 and no ack emitted.
- Request at cycle t in IDLE: `desc_valid_o=1` at t+1. Zero wait cycles when `desc_ready_i` is already high.
- Descriptor handshake at cycle t: `req_ack_o` high and state DATA at t+1; ack low at t+2. The routed path is open from t+1.
- Last beat at t: IDLE at t+1; the next descriptor is valid at t+2 at the earliest.
- Single-beat transfers: a last beat in the first DATA cycle is legal.
- Counter width is `$clog2(TIMEOUT_CYCLES+1)` and saturates at the terminal value.

## Test plan
- Single write, requester 2: `req_valid_i=4'b0100`, length 64, `desc_ready_i=1`, 4 beats with last on beat 4. Required:
  - `desc_valid_o` one cycle after the request, with `desc_id_o=2`.
  - `req_ack_o=4'b0100` for one cycle.
  - 4 beats on `m_w*`.
  - `busy_o` falls the cycle after the last beat.
- Single read, requester 0: `m_rvalid_i` asserted 3 beats, `req_rready_i[0]` toggling. Required:
  - Beats pass only when both valid and ready are high.
  - `req_rvalid_o[3:1]=0` throughout.
  - IDLE after the `rlast` beat.
- Round-robin: all 4 requests held continuously, each transfer 1 beat. Required: grant order 0,1,2,3,0, and each ack is a single-cycle pulse.
- Descriptor backpressure: `desc_ready_i=0` for 5 cycles, then 1. Required:
  - `desc_valid_o` and `desc_o` stable for 6 cycles.
  - Ack appears on the cycle after `desc_ready_i` rises.
- Watchdog: `TIMEOUT_CYCLES=8`, grant a write, then no `wvalid`. Required:
  - `timeout_err_o` rises 8 cycles after DATA entry and stays high.
  - State returns to IDLE and the next request is served.
- Reset mid-DATA: assert `rst_ni=0` asynchronously during beat 2 of 4. Required:
  - All outputs 0 immediately.
  - After release, a pending request from requester 0 is granted first.
